mef_caixa: RTL and testbench

//   Tank-level state machine upstream of the irrigation validator: filters the three tank

---
 rtl/mef_caixa_pkg.sv | 44 ++++
 rtl/mef_caixa_if.sv | 24 ++
 rtl/mef_caixa_filtro_sensor.sv | 45 ++++
 rtl/mef_caixa.sv | 100 ++++++++++
 tb/tb_mef_caixa.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mef_caixa_pkg.sv
// Shared definitions for the tank-level controller and the irrigation validator.
// Provides the FSM state encoding, the published mef1 codes, the registered output
// bundle and the Moore decode from state to outputs.
package mef_caixa_pkg;

  typedef enum logic [2:0] {
    CRITICO  = 3'd0,
    ENCHENDO = 3'd1,
    NORMAL   = 3'd2,
    DRENANDO = 3'd3,
    LIMPANDO = 3'd4,
    ERRO     = 3'd5
  } estado_t;

  localparam logic [1:0] MEF1_CRITICO  = 2'b00;
  localparam logic [1:0] MEF1_ENCHENDO = 2'b01;
  localparam logic [1:0] MEF1_LIMPEZA  = 2'b10;
  localparam logic [1:0] MEF1_NORMAL   = 2'b11;

  typedef struct packed {
    logic [1:0] mef1;
    logic       ve;
    logic       vs;
    logic       limpeza;
    logic       erro_nivel;
  } saidas_t;

  // Moore output decode; VE and VS are never both set and VE is never set in NORMAL.
  function automatic saidas_t decodifica(input estado_t st);
    saidas_t s;
    s = '0;
    case (st)
      CRITICO:  begin s.mef1 = MEF1_CRITICO;  s.ve = 1'b1; end
      ENCHENDO: begin s.mef1 = MEF1_ENCHENDO; s.ve = 1'b1; end
      NORMAL:   begin s.mef1 = MEF1_NORMAL; end
      DRENANDO: begin s.mef1 = MEF1_LIMPEZA;  s.vs = 1'b1; s.limpeza = 1'b1; end
      LIMPANDO: begin s.mef1 = MEF1_LIMPEZA;  s.limpeza = 1'b1; end
      ERRO:     begin s.mef1 = MEF1_CRITICO;  s.erro_nivel = 1'b1; end
      default:  begin s.mef1 = MEF1_CRITICO; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mef_caixa_if.sv
// Sensor/request inputs and valve/status outputs of the tank controller.
//   master: drives sensors and req_limpeza, observes status (environment side)
//   slave : the controller itself
interface mef_caixa_if;
  logic       s_baixo;
  logic       s_medio;
  logic       s_alto;
  logic       req_limpeza;
  logic [1:0] mef1;
  logic       VE;
  logic       VS;
  logic       limpeza;
  logic       erro_nivel;

  modport master (
    output s_baixo, s_medio, s_alto, req_limpeza,
    input  mef1, VE, VS, limpeza, erro_nivel
  );

  modport slave (
    input  s_baixo, s_medio, s_alto, req_limpeza,
    output mef1, VE, VS, limpeza, erro_nivel
  );
endinterface

// File: rtl/mef_caixa_filtro_sensor.sv
// Level-sensor filter: 2-FF synchronizer followed by a debounce counter.
// f only takes a new value after the synchronized input has held it DEB consecutive
// cycles, giving a raw->f latency of DEB+2 cycles.
//   clk, rst_n : clock, async active-low reset
//   d          : raw asynchronous sensor
//   f          : filtered sensor value
module mef_caixa_filtro_sensor #(
  parameter int unsigned DEB = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic f
);

  localparam int unsigned CW = $clog2(DEB + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronizer plus run-length counter of cycles where s2 disagrees with f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      f   <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s2 != f) begin
        if (cnt == CW'(DEB - 1)) begin
          f   <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mef_caixa.sv
// Tank-level controller: filters the three level sensors, checks their consistency and
// runs the fill/drain/cleaning state machine driving the inlet (VE) and drain (VS) valves.
//   clk, rst_n : clock, async active-low reset
//   bus        : sensors + req_limpeza in; mef1, VE, VS, limpeza, erro_nivel out
module mef_caixa
  import mef_caixa_pkg::*;
#(
  parameter int unsigned DEB         = 4,
  parameter int unsigned LIMP_CICLOS = 8,
  parameter int unsigned LIMP_TEMPO  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mef_caixa_if.slave  bus
);

  localparam int unsigned CW_FILL = $clog2(LIMP_CICLOS + 1);
  localparam int unsigned CW_TIM  = $clog2(LIMP_TEMPO + 1);

  logic f_baixo, f_medio, f_alto;
  logic erro;

  estado_t              st, st_nxt;
  logic [CW_FILL-1:0]   fill, fill_nxt;
  logic [CW_TIM-1:0]    tim, tim_nxt;
  saidas_t              saida_q, saida_nxt;

  mef_caixa_filtro_sensor #(.DEB(DEB)) u_filtro_baixo (
    .clk(clk), .rst_n(rst_n), .d(bus.s_baixo), .f(f_baixo));
  mef_caixa_filtro_sensor #(.DEB(DEB)) u_filtro_medio (
    .clk(clk), .rst_n(rst_n), .d(bus.s_medio), .f(f_medio));
  mef_caixa_filtro_sensor #(.DEB(DEB)) u_filtro_alto (
    .clk(clk), .rst_n(rst_n), .d(bus.s_alto), .f(f_alto));

  // A higher mark wet while a lower one is dry is physically impossible.
  assign erro = (f_alto & ~f_medio) | (f_medio & ~f_baixo) | (f_alto & ~f_baixo);

  // State, fill counter, cleaning timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= CRITICO;
      fill    <= '0;
      tim     <= '0;
      saida_q <= '0;
    end else begin
      st      <= st_nxt;
      fill    <= fill_nxt;
      tim     <= tim_nxt;
      saida_q <= saida_nxt;
    end
  end

  // Next state; outputs are the decode of the next state so they line up with st.
  always_comb begin
    st_nxt   = st;
    fill_nxt = fill;
    tim_nxt  = tim;
    if (erro) begin
      st_nxt = ERRO;
    end else begin
      case (st)
        CRITICO: if (f_baixo) st_nxt = ENCHENDO;
        ENCHENDO: begin
          if (f_alto) begin
            st_nxt = NORMAL;
            if (fill != CW_FILL'(LIMP_CICLOS)) fill_nxt = fill + CW_FILL'(1);
          end else if (!f_baixo) begin
            st_nxt = CRITICO;
          end
        end
        NORMAL: begin
          if (!f_baixo)                                           st_nxt = CRITICO;
          else if (bus.req_limpeza || fill == CW_FILL'(LIMP_CICLOS)) st_nxt = DRENANDO;
          else if (!f_medio)                                      st_nxt = ENCHENDO;
        end
        DRENANDO: begin
          if (!f_baixo) begin
            st_nxt   = LIMPANDO;
            tim_nxt  = '0;
            fill_nxt = '0;
          end
        end
        LIMPANDO: begin
          if (tim == CW_TIM'(LIMP_TEMPO - 1)) st_nxt = CRITICO;
          else                                tim_nxt = tim + CW_TIM'(1);
        end
        ERRO:    st_nxt = CRITICO;
        default: st_nxt = CRITICO;
      endcase
    end
    saida_nxt = decodifica(st_nxt);
  end

  assign bus.mef1       = saida_q.mef1;
  assign bus.VE         = saida_q.ve;
  assign bus.VS         = saida_q.vs;
  assign bus.limpeza    = saida_q.limpeza;
  assign bus.erro_nivel = saida_q.erro_nivel;

endmodule

// File: tb/tb_mef_caixa.sv
// Self-checking bench for mef_caixa: directed scenarios followed by randomized sensor
// levels, glitches, cleaning requests and async resets, all compared every cycle
// against a behavioural model of the tank controller.
module tb_mef_caixa;

  localparam int DEB         = 2;
  localparam int LIMP_CICLOS = 2;
  localparam int LIMP_TEMPO  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mef_caixa_if bus ();

  mef_caixa #(.DEB(DEB), .LIMP_CICLOS(LIMP_CICLOS), .LIMP_TEMPO(LIMP_TEMPO)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_chk++;
    if (obs != esp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, esp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_CRIT, M_ENCH, M_NORM, M_DREN, M_LIMP, M_ERRO} m_estado_t;

  m_estado_t m_st;
  int        m_fill;
  int        m_tim;
  bit [2:0]  mf;        // filtered {alto, medio, baixo}
  bit [2:0]  hist[$];   // raw samples, newest first

  task automatic modelo_reset();
    m_st   = M_CRIT;
    m_fill = 0;
    m_tim  = 0;
    mf     = '0;
    hist   = {};
    for (int k = 0; k < DEB + 2; k++) hist.push_back(3'b000);
  endtask

  // One rising edge: FSM sees the filtered levels from before the edge, then the
  // filters flip when the DEB samples taken two edges ago and earlier all disagree.
  task automatic modelo_passo();
    bit [2:0]  raw, v;
    bit        e, muda;
    m_estado_t nst;
    raw = {bus.s_alto, bus.s_medio, bus.s_baixo};
    hist.push_front(raw);
    while (hist.size() > DEB + 2) void'(hist.pop_back());
    e   = (mf[2] && !mf[1]) || (mf[1] && !mf[0]) || (mf[2] && !mf[0]);
    nst = m_st;
    if (e) nst = M_ERRO;
    else begin
      case (m_st)
        M_CRIT: if (mf[0]) nst = M_ENCH;
        M_ENCH: begin
          if (mf[2]) begin
            nst = M_NORM;
            if (m_fill < LIMP_CICLOS) m_fill++;
          end else if (!mf[0]) nst = M_CRIT;
        end
        M_NORM: begin
          if (!mf[0]) nst = M_CRIT;
          else if (bus.req_limpeza || m_fill == LIMP_CICLOS) nst = M_DREN;
          else if (!mf[1]) nst = M_ENCH;
        end
        M_DREN: if (!mf[0]) begin nst = M_LIMP; m_tim = 0; m_fill = 0; end
        M_LIMP: begin
          if (m_tim == LIMP_TEMPO - 1) nst = M_CRIT;
          else m_tim++;
        end
        default: nst = M_CRIT;
      endcase
    end
    m_st = nst;
    for (int i = 0; i < 3; i++) begin
      muda = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) begin
        v = hist[k];
        if (v[i] == mf[i]) muda = 1'b0;
      end
      if (muda) mf[i] = !mf[i];
    end
  endtask

  task automatic compara_saidas();
    int m, ve, vs, lp, er;
    m = 0; ve = 0; vs = 0; lp = 0; er = 0;
    case (m_st)
      M_CRIT: begin m = 0; ve = 1; end
      M_ENCH: begin m = 1; ve = 1; end
      M_NORM: m = 3;
      M_DREN: begin m = 2; vs = 1; lp = 1; end
      M_LIMP: begin m = 2; lp = 1; end
      M_ERRO: begin m = 0; er = 1; end
      default: m = 0;
    endcase
    verifica("mef1", int'(bus.mef1), m);
    verifica("VE", int'(bus.VE), ve);
    verifica("VS", int'(bus.VS), vs);
    verifica("limpeza", int'(bus.limpeza), lp);
    verifica("erro_nivel", int'(bus.erro_nivel), er);
    verifica("inv_ve_vs", int'(bus.VE & bus.VS), 0);
    verifica("inv_ve_normal", int'(bus.VE && bus.mef1 == 2'b11), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    modelo_passo();
    #1;
    compara_saidas();
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sensores(input bit b, input bit m, input bit a);
    bus.s_baixo = b;
    bus.s_medio = m;
    bus.s_alto  = a;
  endtask

  // Async reset away from any edge: outputs must clear with no clock.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    verifica({tag, "_mef1"}, int'(bus.mef1), 0);
    verifica({tag, "_VE"}, int'(bus.VE), 0);
    verifica({tag, "_VS"}, int'(bus.VS), 0);
    verifica({tag, "_limpeza"}, int'(bus.limpeza), 0);
    verifica({tag, "_erro"}, int'(bus.erro_nivel), 0);
    modelo_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit b, m, a;
    int dur;
    bus.req_limpeza = 1'b0;
    sensores(0, 0, 0);
    modelo_reset();

    // 1: reset, then low sensor reaches ENCHENDO exactly DEB+3 edges later
    #12;
    do_reset("rst_ini");
    tick();
    verifica("t1_critico_VE", int'(bus.VE), 1);
    sensores(1, 0, 0);
    tickn(DEB + 2);
    verifica("t1_antes", int'(bus.mef1), 0);
    tick();
    verifica("t1_enchendo", int'(bus.mef1), 1);

    // 2: fill and hysteresis
    sensores(1, 1, 1);
    tickn(10);
    verifica("t2_normal", int'(bus.mef1), 3);
    sensores(1, 1, 0);
    tickn(10);
    verifica("t2_sem_alto", int'(bus.mef1), 3);
    sensores(1, 0, 0);
    tickn(10);
    verifica("t2_abaixo_medio", int'(bus.mef1), 1);
    verifica("t2_abaixo_medio_VE", int'(bus.VE), 1);

    // 3: second fill triggers automatic cleaning
    sensores(1, 1, 1);
    tickn(10);
    verifica("t3_drenando", int'(bus.mef1), 2);
    verifica("t3_drenando_VS", int'(bus.VS), 1);
    verifica("t3_drenando_limp", int'(bus.limpeza), 1);
    sensores(0, 0, 0);
    tickn(DEB + 6);
    verifica("t3_limpando", int'(bus.mef1), 2);
    verifica("t3_limpando_VS", int'(bus.VS), 0);
    tick();
    verifica("t3_critico", int'(bus.mef1), 0);
    verifica("t3_critico_VE", int'(bus.VE), 1);
    sensores(1, 1, 1);
    tickn(12);
    verifica("t3_contador_zerado", int'(bus.mef1), 3);

    // 4: inconsistent sensors -> ERRO, then recovery
    sensores(1, 0, 1);
    tickn(8);
    verifica("t4_erro_mef1", int'(bus.mef1), 0);
    verifica("t4_erro_VE", int'(bus.VE), 0);
    verifica("t4_erro_flag", int'(bus.erro_nivel), 1);
    sensores(1, 0, 0);
    tickn(10);
    verifica("t4_recupera", int'(bus.mef1), 1);

    // 5: manual request in NORMAL, then reset mid-LIMPANDO
    do_reset("rst_t5pre");
    sensores(1, 1, 1);
    tickn(12);
    verifica("t5_normal", int'(bus.mef1), 3);
    bus.req_limpeza = 1'b1;
    tick();
    bus.req_limpeza = 1'b0;
    verifica("t5_req_drena", int'(bus.mef1), 2);
    verifica("t5_req_drena_VS", int'(bus.VS), 1);
    sensores(0, 0, 0);
    tickn(DEB + 4);
    verifica("t5_limpando_VS", int'(bus.VS), 0);
    do_reset("rst_limpando");

    // 6: short glitch on s_medio in NORMAL is filtered
    sensores(1, 1, 1);
    tickn(12);
    sensores(1, 0, 1);
    tick();
    sensores(1, 1, 1);
    tickn(8);
    verifica("t6_glitch", int'(bus.mef1), 3);

    // Randomized: held levels, occasional inconsistent combos, glitches, requests, resets
    b = 1; m = 1; a = 1; dur = 0;
    for (int c = 0; c < 1500; c++) begin
      if (dur == 0) begin
        dur = $urandom_range(1, 12);
        if ($urandom_range(0, 99) < 12) begin
          b = 1'($urandom); m = 1'($urandom); a = 1'($urandom);
        end else begin
          case ($urandom_range(0, 3))
            0: begin b = 0; m = 0; a = 0; end
            1: begin b = 1; m = 0; a = 0; end
            2: begin b = 1; m = 1; a = 0; end
            default: begin b = 1; m = 1; a = 1; end
          endcase
        end
      end
      dur--;
      sensores(b, m, a);
      if ($urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 2))
          0: bus.s_baixo = !b;
          1: bus.s_medio = !m;
          default: bus.s_alto = !a;
        endcase
      end
      bus.req_limpeza = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 999) < 4) do_reset("rst_aleat");
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
